multi_spi_matrix_tx: RTL and testbench

MULTI_SPI_MATRIX_TX -- requirements
Module: multi_spi_matrix_tx

---
 rtl/multi_spi_matrix_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_multi_spi_matrix_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_spi_matrix_tx.sv
// Multi-lane SPI matrix transmitter: 595 chip-select chain picks one matrix, then bytes stream on all MOSI lanes.
// Latency: frame = per matrix (select shift + latch + fetch + bytes*8 bits + gap) plus deselect; rd_data used 1 cycle after rd_req.
// Backpressure: none; start ignored while busy. Define MTX_TX_LSB_FIRST_EN for LSB-first bytes (MSB-first otherwise).
module multi_spi_matrix_tx #(
  parameter int CHANNEL_NUMBER     = 3,
  parameter int MATRIX_PER_CHANNEL = 4,
  parameter int BYTES_PER_MATRIX   = 384,
  parameter int DIV_FACTOR         = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   start,
  output logic                                                   rd_req,
  output logic [$clog2(MATRIX_PER_CHANNEL*BYTES_PER_MATRIX)-1:0] rd_addr,
  input  logic [8*CHANNEL_NUMBER-1:0]                            rd_data,
  output logic                                                   spi_clk,
  output logic [CHANNEL_NUMBER-1:0]                              spi_mosi,
  output logic                                                   shift_clk,
  output logic                                                   shift_ser,
  output logic                                                   shift_stcp,
  output logic                                                   shift_en,
  output logic                                                   busy,
  output logic                                                   done
);

  localparam int AW  = $clog2(MATRIX_PER_CHANNEL*BYTES_PER_MATRIX);
  localparam int MW  = (MATRIX_PER_CHANNEL > 1) ? $clog2(MATRIX_PER_CHANNEL) : 1;
  localparam int BW  = (BYTES_PER_MATRIX > 1) ? $clog2(BYTES_PER_MATRIX) : 1;
  localparam int SHN = (MATRIX_PER_CHANNEL > 8) ? MATRIX_PER_CHANNEL : 8;
  localparam int BCW = $clog2(SHN);
  localparam int CW  = $clog2(2*DIV_FACTOR + 1);
  localparam int DW  = 8*CHANNEL_NUMBER;

  typedef enum logic [2:0] {
    IDLE, SEL_SHIFT, SEL_LATCH, SEND, GAP, DESEL_SHIFT, DESEL_LATCH, DONE
  } state_t;

  state_t          state;
  logic [MW-1:0]   m_idx;
  logic [BCW-1:0]  bit_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [CW-1:0]   div_cnt;
  logic [AW-1:0]   fetch_addr;
  logic [DW-1:0]   cur;
  logic [DW-1:0]   nxt;
  logic            pend;
  logic            first;

  // Chain bit idx lands in stage (N-1-idx): the first bit shifted ends up furthest down the chain.
  function automatic logic chain_bit(input logic [BCW-1:0] idx, input logic [MW-1:0] mi,
                                     input logic desel);
    chain_bit = desel || ((MATRIX_PER_CHANNEL - 1 - int'(idx)) != int'(mi));
  endfunction

  function automatic logic [CHANNEL_NUMBER-1:0] lane_bits(input logic [DW-1:0] d,
                                                          input logic [2:0] b);
    logic [CHANNEL_NUMBER-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNEL_NUMBER; k++) begin
`ifdef MTX_TX_LSB_FIRST_EN
      r[k] = d[8*k + int'(b)];
`else
      r[k] = d[8*k + 7 - int'(b)];
`endif
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      m_idx      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      div_cnt    <= '0;
      fetch_addr <= '0;
      cur        <= '0;
      nxt        <= '0;
      pend       <= 1'b0;
      first      <= 1'b0;
      spi_clk    <= 1'b0;
      spi_mosi   <= '0;
      shift_clk  <= 1'b0;
      shift_ser  <= 1'b1;
      shift_stcp <= 1'b0;
      shift_en   <= 1'b1;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_req <= 1'b0;
      // Fetch data arrives the cycle after rd_req; park it in nxt until the byte boundary.
      pend   <= rd_req;
      if (pend) nxt <= rd_data;

      case (state)
        IDLE: begin
          if (start) begin
            state      <= SEL_SHIFT;
            busy       <= 1'b1;
            m_idx      <= '0;
            fetch_addr <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            shift_clk  <= 1'b0;
            shift_ser  <= chain_bit('0, '0, 1'b0);
          end
        end

        SEL_SHIFT, DESEL_SHIFT: begin
          if (div_cnt != CW'(DIV_FACTOR - 1)) begin
            div_cnt <= div_cnt + CW'(1);
          end else begin
            div_cnt <= '0;
            if (!shift_clk) begin
              shift_clk <= 1'b1;
            end else begin
              shift_clk <= 1'b0;
              if (bit_cnt == BCW'(MATRIX_PER_CHANNEL - 1)) begin
                shift_stcp <= 1'b1;
                shift_en   <= 1'b0;
                state      <= (state == SEL_SHIFT) ? SEL_LATCH : DESEL_LATCH;
              end else begin
                bit_cnt   <= bit_cnt + BCW'(1);
                shift_ser <= chain_bit(bit_cnt + BCW'(1), m_idx, state == DESEL_SHIFT);
              end
            end
          end
        end

        SEL_LATCH: begin
          if (div_cnt != CW'(DIV_FACTOR - 1)) begin
            div_cnt <= div_cnt + CW'(1);
          end else begin
            div_cnt    <= '0;
            shift_stcp <= 1'b0;
            rd_req     <= 1'b1;
            rd_addr    <= fetch_addr;
            fetch_addr <= fetch_addr + AW'(1);
            first      <= 1'b1;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            state      <= SEND;
          end
        end

        SEND: begin
          if (first) begin
            // Hold spi_clk low until the first byte of this matrix has landed in nxt.
            if (!rd_req && !pend) begin
              first    <= 1'b0;
              cur      <= nxt;
              spi_mosi <= lane_bits(nxt, 3'd0);
              div_cnt  <= '0;
            end
          end else if (div_cnt != CW'(DIV_FACTOR - 1)) begin
            div_cnt <= div_cnt + CW'(1);
          end else begin
            div_cnt <= '0;
            if (!spi_clk) begin
              spi_clk <= 1'b1;
            end else begin
              spi_clk <= 1'b0;
              if (bit_cnt != BCW'(7)) begin
                bit_cnt  <= bit_cnt + BCW'(1);
                spi_mosi <= lane_bits(cur, 3'(bit_cnt + BCW'(1)));
                if (bit_cnt == BCW'(6) && byte_cnt != BW'(BYTES_PER_MATRIX - 1)) begin
                  rd_req     <= 1'b1;
                  rd_addr    <= fetch_addr;
                  fetch_addr <= fetch_addr + AW'(1);
                end
              end else if (byte_cnt != BW'(BYTES_PER_MATRIX - 1)) begin
                byte_cnt <= byte_cnt + BW'(1);
                bit_cnt  <= '0;
                cur      <= nxt;
                spi_mosi <= lane_bits(nxt, 3'd0);
              end else begin
                state <= GAP;
              end
            end
          end
        end

        GAP: begin
          if (div_cnt != CW'(2*DIV_FACTOR - 1)) begin
            div_cnt <= div_cnt + CW'(1);
          end else begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_clk <= 1'b0;
            if (m_idx != MW'(MATRIX_PER_CHANNEL - 1)) begin
              m_idx     <= m_idx + MW'(1);
              shift_ser <= chain_bit('0, m_idx + MW'(1), 1'b0);
              state     <= SEL_SHIFT;
            end else begin
              shift_ser <= chain_bit('0, m_idx, 1'b1);
              state     <= DESEL_SHIFT;
            end
          end
        end

        DESEL_LATCH: begin
          if (div_cnt != CW'(DIV_FACTOR - 1)) begin
            div_cnt <= div_cnt + CW'(1);
          end else begin
            div_cnt    <= '0;
            shift_stcp <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_spi_matrix_tx.sv
// Bench for multi_spi_matrix_tx: SPI slave + 595 chain model, byte-memory reference and per-cycle protocol checks.
// Directed frame, restart-while-busy, mid-frame reset, then randomized data frames.
module tb_multi_spi_matrix_tx;
  localparam int CH = 3, M = 2, B = 4, DIV = 2, N = M*B, AW = $clog2(N);
  localparam int BIT_CYC = 2*DIV;
`ifdef MTX_TX_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic rd_req;
  logic [AW-1:0] rd_addr;
  logic [8*CH-1:0] rd_data = '0;
  logic spi_clk;
  logic [CH-1:0] spi_mosi;
  logic shift_clk, shift_ser, shift_stcp, shift_en, busy, done;

  multi_spi_matrix_tx #(.CHANNEL_NUMBER(CH), .MATRIX_PER_CHANNEL(M),
                        .BYTES_PER_MATRIX(B), .DIV_FACTOR(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .shift_clk(shift_clk),
    .shift_ser(shift_ser), .shift_stcp(shift_stcp), .shift_en(shift_en),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] mem [CH][N];

  function automatic logic [8*CH-1:0] pack(input logic [AW-1:0] a);
    logic [8*CH-1:0] r;
    for (int k = 0; k < CH; k++) r[8*k +: 8] = mem[k][a];
    return r;
  endfunction

  always @(posedge clk) if (rd_req) rd_data <= pack(rd_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int min_v);
    checks++;
    if (act < min_v) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min_v);
    end
  endtask

  // ---------------- reference model / monitor ----------------
  int cyc = 0, last_mosi_chg = 0, last_byte_cyc = 0, nbits = 0;
  int rx_idx = 0, exp_addr = 0, rise_cnt = 0;
  int done_cnt = 0, rdreq_total = 0, last_frame_rdreq = 0;
  logic p_spi, p_sclk, p_ser, p_stcp, p_done;
  logic [CH-1:0] p_mosi;
  logic [7:0] acc [CH];
  logic [M-1:0] sr = '1, latched = '1, exp_pat;
  logic sel_valid = 1'b0, latch_seen = 1'b0, first_bit_b1 = 1'b0;
  logic [7:0] got [CH][N];
  logic [M-1:0] pat_seen [M];
  int rises_seen [M];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      nbits = 0; rx_idx = 0; exp_addr = 0; rise_cnt = 0;
      sel_valid = 1'b0; latch_seen = 1'b0; last_mosi_chg = cyc;
    end else begin
      if (rd_req) begin
        chk("rd_addr", rd_addr, exp_addr);
        chk("busy_on_fetch", busy, 1);
        exp_addr++;
        rdreq_total++;
      end
      if (spi_mosi !== p_mosi) last_mosi_chg = cyc;
      if (spi_clk) chk("mosi_stable_while_high", spi_mosi, p_mosi);
      if (!busy) chk("spi_clk_idle_low", spi_clk, 0);
      if (spi_clk && !p_spi) begin
        chk_min("mosi_setup", cyc - last_mosi_chg, DIV);
        rise_cnt++;
        for (int k = 0; k < CH; k++) acc[k][LSB_FIRST ? nbits : 7 - nbits] = spi_mosi[k];
        if (nbits == 0 && rx_idx == 1) first_bit_b1 = spi_mosi[0];
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (rx_idx < N) begin
            exp_pat = '1;
            exp_pat[rx_idx / B] = 1'b0;
            chk("select_pattern", latched, exp_pat);
            if (rx_idx % B == 0) pat_seen[rx_idx / B] = latched;
            else chk("byte_interval", cyc - last_byte_cyc, 8*BIT_CYC);
            for (int k = 0; k < CH; k++) begin
              got[k][rx_idx] = acc[k];
              chk($sformatf("lane%0d_byte%0d", k, rx_idx), acc[k], mem[k][rx_idx]);
            end
          end else begin
            chk("byte_overrun", rx_idx, N - 1);
          end
          last_byte_cyc = cyc;
          rx_idx++;
        end
      end
      if (shift_clk) chk("ser_stable_while_high", shift_ser, p_ser);
      if (shift_clk && !p_sclk) sr = {sr[M-2:0], shift_ser};
      if (shift_stcp && !p_stcp) begin
        if (sel_valid) begin
          chk("rises_per_matrix", rise_cnt, 8*B);
          for (int m = 0; m < M; m++) if (!latched[m]) rises_seen[m] = rise_cnt;
        end
        latched = sr;
        sel_valid = (sr != '1);
        latch_seen = 1'b1;
        rise_cnt = 0;
      end
      chk("shift_en", shift_en, latch_seen ? 1'b0 : 1'b1);
      if (done) begin
        chk("done_single_cycle", p_done, 0);
        chk("busy_at_done", busy, 0);
        chk("frame_fetches", exp_addr, N);
        chk("frame_bytes", rx_idx, N);
        chk("deselect_pattern", latched, {M{1'b1}});
        chk("partial_bits_at_done", nbits, 0);
        last_frame_rdreq = exp_addr;
        exp_addr = 0;
        rx_idx = 0;
        done_cnt++;
      end
    end
    p_spi = spi_clk; p_sclk = shift_clk; p_ser = shift_ser; p_stcp = shift_stcp;
    p_done = done; p_mosi = spi_mosi;
  end

  // ---------------- stimulus ----------------
  task automatic fill_directed();
    for (int k = 0; k < CH; k++)
      for (int a = 0; a < N; a++) mem[k][a] = 8'(a + 16*k);
  endtask

  task automatic fill_random();
    for (int k = 0; k < CH; k++)
      for (int a = 0; a < N; a++) mem[k][a] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_spi_clk"}, spi_clk, 0);
    chk({tag, "_spi_mosi"}, spi_mosi, 0);
    chk({tag, "_shift_clk"}, shift_clk, 0);
    chk({tag, "_shift_ser"}, shift_ser, 1);
    chk({tag, "_shift_stcp"}, shift_stcp, 0);
    chk({tag, "_shift_en"}, shift_en, 1);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  int d0, r0;
  bit hit;

  initial begin
    fill_directed();
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset_idle");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Directed frame with addr+16k data
    d0 = done_cnt;
    pulse_start();
    chk("busy_after_start", busy, 1);
    wait_done(3000);
    chk("t1_lane0_b0", got[0][0], 8'h00);
    chk("t1_lane0_b3", got[0][3], 8'h03);
    chk("t1_lane0_b4", got[0][4], 8'h04);
    chk("t1_lane0_b7", got[0][7], 8'h07);
    chk("t1_lane1_b5", got[1][5], 8'h15);
    chk("t1_lane2_b0", got[2][0], 8'h20);
    chk("t1_lane2_b7", got[2][7], 8'h27);
    chk("t1_pat_matrix0", pat_seen[0], 2'b10);
    chk("t1_pat_matrix1", pat_seen[1], 2'b01);
    chk("t1_pat_after_desel", latched, 2'b11);
    chk("t1_rises_matrix0", rises_seen[0], 32);
    chk("t1_rises_matrix1", rises_seen[1], 32);
    chk("t1_fetch_count", last_frame_rdreq, 8);
    chk("t1_first_bit_of_0x01", first_bit_b1, LSB_FIRST ? 1'b1 : 1'b0);
    chk("t1_done_count", done_cnt - d0, 1);

    // Restart requests while busy must be ignored
    repeat (10) @(posedge clk);
    d0 = done_cnt; r0 = rdreq_total;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(5, 50)) @(negedge clk);
      chk("busy_at_restart", busy, 1);
      pulse_start();
    end
    wait_done(3000);
    repeat (400) @(negedge clk);
    chk("t2_done_count", done_cnt - d0, 1);
    chk("t2_fetch_count", rdreq_total - r0, 8);

    // Reset during byte 2 of matrix 1
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge clk);
      hit = (rx_idx == B + 2);
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL t3_reach_byte2_m1: rx_idx=%0d never reached %0d", rx_idx, B + 2);
    end
    repeat ($urandom_range(1, 12)) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset("reset_midframe");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    d0 = done_cnt; r0 = rdreq_total;
    pulse_start();
    wait_done(3000);
    chk("t3_done_count", done_cnt - d0, 1);
    chk("t3_fetch_count", rdreq_total - r0, 8);
    chk("t3_lane0_b0", got[0][0], 8'h00);
    chk("t3_lane2_b6", got[2][6], 8'h26);

    // Randomized data frames
    for (int f = 0; f < 4; f++) begin
      fill_random();
      repeat ($urandom_range(1, 20)) @(posedge clk);
      d0 = done_cnt;
      pulse_start();
      wait_done(3000);
      chk($sformatf("rand%0d_done_count", f), done_cnt - d0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
